// File: rtl/lift_request_sequencer.sv
// rtl/lift_request_sequencer.sv - single-reader lift sequencer: pops floor requests, travels floor by floor, dwells with door open.
module lift_request_sequencer #(
  parameter int NUM_FLOORS    = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic       i_clock,
  input  logic       i_rst_n,
  input  logic       i_fifo_empty,
  input  logic [3:0] i_rd_data,
  input  logic       i_door_hold,
  input  logic       i_stop,
  output logic       o_rd_en,
  output logic [3:0] o_current_floor,
  output logic [3:0] o_target_floor,
  output logic       o_move_up,
  output logic       o_move_down,
  output logic       o_door_open,
  output logic       o_busy,
  output logic       o_req_err
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [4:0]    NF          = 5'(NUM_FLOORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] travel_q, travel_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;
  logic [3:0]    floor_q, floor_d;
  logic [3:0]    target_q, target_d;
  logic          rd_en_q, rd_en_d;
  logic          req_err_q, req_err_d;
  logic          move_up_q, move_up_d;
  logic          move_down_q, move_down_d;
  logic          door_open_q, door_open_d;
  logic          busy_q, busy_d;

  logic [3:0]    floor_up;
  logic [3:0]    floor_dn;
  logic          req_valid;

  assign floor_up  = floor_q + 4'd1;
  assign floor_dn  = floor_q - 4'd1;
  assign req_valid = ({1'b0, i_rd_data} < NF);

  always_comb begin
    state_d    = state_q;
    travel_d   = travel_q;
    door_cnt_d = door_cnt_q;
    floor_d    = floor_q;
    target_d   = target_q;
    rd_en_d    = 1'b0;
    req_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!i_fifo_empty && !i_stop) begin
          state_d = S_FETCH;
          rd_en_d = 1'b1;
        end
      end

      // The read strobe is already committed, so the fetch/latch pair ignores i_stop.
      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        if (!req_valid) begin
          req_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          target_d = i_rd_data;
          if (i_rd_data > floor_q) begin
            state_d = S_MOVE_UP;
          end else if (i_rd_data < floor_q) begin
            state_d = S_MOVE_DOWN;
          end else begin
            state_d = S_DOOR;
          end
        end
      end

      S_MOVE_UP: begin
        if (!i_stop) begin
          if (travel_q == TRAVEL_LAST) begin
            travel_d = '0;
            floor_d  = floor_up;
            if (floor_up == target_q) begin
              state_d = S_DOOR;
            end
          end else begin
            travel_d = travel_q + 1'b1;
          end
        end
      end

      S_MOVE_DOWN: begin
        if (!i_stop) begin
          if (travel_q == TRAVEL_LAST) begin
            travel_d = '0;
            floor_d  = floor_dn;
            if (floor_dn == target_q) begin
              state_d = S_DOOR;
            end
          end else begin
            travel_d = travel_q + 1'b1;
          end
        end
      end

      // Stop takes priority over door hold: the dwell counter freezes instead of clearing.
      S_DOOR: begin
        if (!i_stop) begin
          if (i_door_hold) begin
            door_cnt_d = '0;
          end else if (door_cnt_q == DOOR_LAST) begin
            door_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            door_cnt_d = door_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    move_up_d   = (state_d == S_MOVE_UP) && !i_stop;
    move_down_d = (state_d == S_MOVE_DOWN) && !i_stop;
    door_open_d = (state_d == S_DOOR);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      travel_q    <= '0;
      door_cnt_q  <= '0;
      floor_q     <= '0;
      target_q    <= '0;
      rd_en_q     <= 1'b0;
      req_err_q   <= 1'b0;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      travel_q    <= travel_d;
      door_cnt_q  <= door_cnt_d;
      floor_q     <= floor_d;
      target_q    <= target_d;
      rd_en_q     <= rd_en_d;
      req_err_q   <= req_err_d;
      move_up_q   <= move_up_d;
      move_down_q <= move_down_d;
      door_open_q <= door_open_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rd_en         = rd_en_q;
  assign o_current_floor = floor_q;
  assign o_target_floor  = target_q;
  assign o_move_up       = move_up_q;
  assign o_move_down     = move_down_q;
  assign o_door_open     = door_open_q;
  assign o_busy          = busy_q;
  assign o_req_err       = req_err_q;

endmodule

// File: doc/lift_request_sequencer.md
Name: lift_request_sequencer

Overview:
- Controller that drains the 16-deep, 4-bit floor-request FIFO one entry at a time and sequences the car.
- Per request: pops the FIFO, travels floor-by-floor to the target with a per-floor travel timer, then holds the door open for a timed dwell.
- Sits between the request FIFO (read side) and the motor/door drive logic; it is the FIFO's only reader.

Parameters:
- NUM_FLOORS, 16, number of valid floors (0..NUM_FLOORS-1); requests >= NUM_FLOORS are invalid.
- TRAVEL_CYCLES, 8, clock cycles to move one floor; must be >= 1.
- DOOR_CYCLES, 16, clock cycles the door stays open; must be >= 1.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_fifo_empty  input  1  FIFO empty flag.
- i_rd_data  input  4  FIFO read data, valid the cycle after o_rd_en is high.
- i_door_hold  input  1  door obstruction/hold button.
- i_stop  input  1  emergency stop; freezes all timers and motion while high.
- o_rd_en  output  1  FIFO read strobe; one-cycle pulse, registered.
- o_current_floor  output  4  floor the car is at.
- o_target_floor  output  4  latched destination.
- o_move_up  output  1  motor up command.
- o_move_down  output  1  motor down command.
- o_door_open  output  1  door open command.
- o_busy  output  1  high in every state except IDLE.
- o_req_err  output  1  one-cycle pulse when an invalid request is discarded.

Behaviour:
- Reset (async, i_rst_n low): state=IDLE. All outputs 0; o_current_floor=0, o_target_floor=0. Travel and door counters are 0. Reset mid-travel abandons the request; the popped entry is lost.
- All outputs are registered.
- States: IDLE, FETCH, LATCH, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE:
  - If i_fifo_empty=0 and i_stop=0, go to FETCH.
  - Otherwise stay.
- FETCH: o_rd_en=1 for exactly this one cycle; go to LATCH. o_rd_en is never high while i_fifo_empty=1.
- LATCH: sample i_rd_data.
  - If >= NUM_FLOORS: pulse o_req_err and go to IDLE. o_target_floor is unchanged.
  - Otherwise o_target_floor<=i_rd_data.
    - target > current: go to MOVE_UP.
    - target < current: go to MOVE_DOWN.
    - target == current: go to DOOR.
- MOVE_UP / MOVE_DOWN:
  - o_move_up or o_move_down =1 respectively. The two are never both high.
  - Travel counter counts 0..TRAVEL_CYCLES-1. At terminal count, o_current_floor is incremented or decremented by 1 and the counter clears.
  - If the new floor equals the target, go to DOOR; otherwise continue in the same state.
  - Floor arithmetic never wraps; range is 0..NUM_FLOORS-1 by construction.
- DOOR:
  - o_door_open=1; door counter counts 0..DOOR_CYCLES-1.
  - i_door_hold=1 clears the counter each cycle, so the door stays open while held.
  - At terminal count with i_door_hold=0: o_door_open<=0 and go to IDLE.
- Latency and back-to-back requests: from IDLE with a non-empty FIFO, o_rd_en rises 1 cycle later. The next FETCH can occur no earlier than 1 cycle after DOOR exit, because IDLE lasts one cycle.
- i_stop=1:
  - All state, counter and floor registers hold.
  - o_move_up and o_move_down are forced to 0; o_door_open is held at its value.
  - In IDLE, no FETCH is started.
  - In FETCH, the read completes anyway: o_rd_en was already committed, and data must be captured in LATCH regardless of i_stop.
  - On deassert, operation resumes exactly where it stopped.
- Simultaneous i_stop and i_door_hold in DOOR: stop wins and the counter holds rather than clears.
- Duplicate requests are not merged; each FIFO entry is served in order.

Test Plan:
- Reset/idle: release reset with FIFO empty -> o_rd_en stays 0 for 50 cycles; o_busy=0, o_current_floor=0, all motion/door outputs 0.
- Single up trip (TRAVEL_CYCLES=4, DOOR_CYCLES=6): push 3 from floor 0 -> one o_rd_en pulse; o_move_up high for 12 cycles; o_current_floor steps 1,2,3 every 4 cycles; o_door_open high 6 cycles; then IDLE.
- Sequence 5,2,2,15: FIFO pre-filled -> four o_rd_en pulses, one per request, in order.
  - Car goes up to 5, then down to 2 (12 cycles o_move_down).
  - Second 2 opens the door with no motion.
  - 15 is reached after 13 floor steps.
  - FIFO ends empty, o_busy=0.
- Invalid request: NUM_FLOORS=10, push 12 -> o_req_err pulses once, no motion, o_target_floor unchanged, next entry served normally.
- Door hold: hold i_door_hold high for 20 cycles mid-dwell -> o_door_open stays high throughout, then closes exactly 6 cycles after release.
- Stop/reset mid-travel:
  - Assert i_stop for 10 cycles during MOVE_UP -> motion outputs go to 0, o_current_floor frozen; on release the remaining travel count resumes with no extra or lost cycles.
  - Assert i_rst_n=0 mid-travel -> all outputs 0 asynchronously, o_current_floor=0.
